// File: rtl/sram_pkg.sv
// Shared definitions for the 16-bit SRAM bus.
// The MEM-stage SRAM controller and the sram_responder both use this package.
package sram_pkg;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;

    // Bit positions of the active-low sramCtrl bits
    localparam int WE_N_B = 0;
    localparam int OE_N_B = 1;
    localparam int CE_N_B = 2;
    localparam int LB_N_B = 3;
    localparam int UB_N_B = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_DRIVE = 2'd2
    } rd_state_t;
endpackage

// File: rtl/sram_byte_array.sv
// Word-wide storage with a per-byte write mask and an asynchronous read port.
// The contents are never reset.
module sram_byte_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);
    logic [15:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be[0]) mem[waddr][7:0]  <= wdata[7:0];
            if (be[1]) mem[waddr][15:8] <= wdata[15:8];
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sram_responder.sv
// Behavioural SRAM chip replacement. It has a byte-lane write port and reads with
// a programmable latency. It also exposes status flags and access counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int MEM_AW   = 10,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire  [SRAM_DW-1:0]  sramData,
    input  logic [SRAM_AW-1:0]  sramAddress,
    input  logic [4:0]          sramCtrl,
    output logic                rdValid,
    output logic                busy,
    output logic                conflict,
    output logic [CNT_W-1:0]    readCount,
    output logic [CNT_W-1:0]    writeCount
);
    localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

    rd_state_t          state;
    logic [3:0]         lat_cnt;
    logic [SRAM_AW-1:0] rd_addr;
    logic [15:0]        rdata;

    logic wr, rd, addr_same, drive_en;

    assign wr        = !sramCtrl[CE_N_B] && !sramCtrl[WE_N_B];
    assign rd        = !sramCtrl[CE_N_B] && !sramCtrl[OE_N_B] && sramCtrl[WE_N_B];
    assign addr_same = (sramAddress == rd_addr);

    sram_byte_array #(.AW(MEM_AW)) u_array (
        .clk   (clk),
        .we    (wr),
        .be    ({!sramCtrl[UB_N_B], !sramCtrl[LB_N_B]}),
        .waddr (sramAddress[MEM_AW-1:0]),
        .wdata (sramData),
        .raddr (rd_addr[MEM_AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            rd_addr    <= '0;
            rdValid    <= 1'b0;
            busy       <= 1'b0;
            conflict   <= 1'b0;
            readCount  <= '0;
            writeCount <= '0;
        end else if (wr) begin
            // A write always wins and drops any read in flight.
            state      <= ST_IDLE;
            rdValid    <= 1'b0;
            busy       <= 1'b0;
            writeCount <= writeCount + 1'b1;
            if (!sramCtrl[OE_N_B]) conflict <= 1'b1;
        end else if (!rd) begin
            state   <= ST_IDLE;
            rdValid <= 1'b0;
            busy    <= 1'b0;
        end else if (state == ST_IDLE || !addr_same) begin
            // A new request, or a change of address, restarts the latency count.
            rd_addr <= sramAddress;
            lat_cnt <= LAT_M1;
            if (READ_LAT == 1) begin
                state     <= ST_RD_DRIVE;
                rdValid   <= 1'b1;
                busy      <= 1'b0;
                readCount <= readCount + 1'b1;
            end else begin
                state   <= ST_RD_WAIT;
                rdValid <= 1'b0;
                busy    <= 1'b1;
            end
        end else if (state == ST_RD_WAIT) begin
            if (lat_cnt == 4'd1) begin
                state     <= ST_RD_DRIVE;
                rdValid   <= 1'b1;
                busy      <= 1'b0;
                readCount <= readCount + 1'b1;
            end
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // The lane enables follow sramCtrl combinationally, so the bus is released
    // in the same cycle that the controller deasserts.
    assign drive_en = (state == ST_RD_DRIVE) && rd;
    assign sramData[7:0]  = (drive_en && !sramCtrl[LB_N_B]) ? rdata[7:0]  : 8'hzz;
    assign sramData[15:8] = (drive_en && !sramCtrl[UB_N_B]) ? rdata[15:8] : 8'hzz;
endmodule

// File: tb/tb_sram_responder.sv
// Randomized and directed bench for sram_responder.
// A reference model tracks how many consecutive cycles the same read request has been held.
module tb_sram_responder;
    import sram_pkg::*;

    localparam int MEM_AW = 6;
    localparam int LAT    = 3;
    localparam int CNT_W  = 4;

    logic        clk = 1'b0;
    logic        rst;
    wire  [15:0] sram_data;
    logic [15:0] drv;
    logic        drv_en;
    logic [17:0] addr;
    logic [4:0]  ctl;
    logic        rd_valid, busy, conflict;
    logic [CNT_W-1:0] read_count, write_count;

    always #5 clk = ~clk;

    assign sram_data = drv_en ? drv : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (sram_data[i]);
    end

    sram_responder #(.MEM_AW(MEM_AW), .READ_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .sramData    (sram_data),
        .sramAddress (addr),
        .sramCtrl    (ctl),
        .rdValid     (rd_valid),
        .busy        (busy),
        .conflict    (conflict),
        .readCount   (read_count),
        .writeCount  (write_count)
    );

    // Reference model
    logic [15:0] mmem [2**MEM_AW];
    int          streak;
    logic [17:0] maddr;
    logic        mconf;
    int          rcnt, wcnt;
    int          tests = 0, fails = 0;

    // ctl layout {UB_N, LB_N, CE_N, OE_N, WE_N}
    localparam logic [4:0] C_IDLE = 5'b11111;
    localparam logic [4:0] C_RD   = 5'b00001;
    localparam logic [4:0] C_WR   = 5'b00010;
    localparam logic [4:0] C_CONF = 5'b00000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic       rdc;
        logic [15:0] word, exp_bus;
        rdc  = !ctl[CE_N_B] && !ctl[OE_N_B] && ctl[WE_N_B];
        word = mmem[maddr[MEM_AW-1:0]];
        exp_bus = drv_en ? drv : 16'hFFFF;
        if (streak >= LAT && rdc && !ctl[LB_N_B]) exp_bus[7:0]  = word[7:0];
        if (streak >= LAT && rdc && !ctl[UB_N_B]) exp_bus[15:8] = word[15:8];
        chk("bus",      32'(sram_data),   32'(exp_bus));
        chk("rdValid",  32'(rd_valid),    32'(streak >= LAT));
        chk("busy",     32'(busy),        32'(streak > 0 && streak < LAT));
        chk("conflict", 32'(conflict),    32'(mconf));
        chk("readCnt",  32'(read_count),  32'(rcnt % (1 << CNT_W)));
        chk("writeCnt", 32'(write_count), 32'(wcnt % (1 << CNT_W)));
    endtask

    task automatic step(input logic [17:0] a, input logic [4:0] c, input logic [15:0] d);
        logic w, r;
        addr = a; ctl = c; drv = d;
        w = !c[CE_N_B] && !c[WE_N_B];
        r = !c[CE_N_B] && !c[OE_N_B] && c[WE_N_B];
        drv_en = w;
        @(posedge clk);
        if (w) begin
            if (!c[LB_N_B]) mmem[a[MEM_AW-1:0]][7:0]  = d[7:0];
            if (!c[UB_N_B]) mmem[a[MEM_AW-1:0]][15:8] = d[15:8];
            wcnt++;
            if (!c[OE_N_B]) mconf = 1'b1;
            streak = 0;
        end else if (!r) begin
            streak = 0;
        end else if (streak > 0 && a == maddr) begin
            if (streak < LAT) begin
                streak++;
                if (streak == LAT) rcnt++;
            end
        end else begin
            streak = 1;
            maddr  = a;
            if (LAT == 1) rcnt++;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [17:0] ra;
        logic [4:0]  rc;
        int          r;
        streak = 0; maddr = '0; mconf = 0; rcnt = 0; wcnt = 0;
        rst = 1'b0; addr = '0; ctl = C_IDLE; drv = '0; drv_en = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b1;

        // Fill every word so the model and the array agree
        for (int i = 0; i < 2**MEM_AW; i++) step(18'(i), C_WR, 16'($urandom));

        // Reset in the middle of a read
        for (int i = 0; i < LAT + 1; i++) step(18'h10, C_RD, 16'h0);
        #2 rst = 1'b0;
        #1;
        streak = 0; rcnt = 0; wcnt = 0; mconf = 0;
        check_all();
        rst = 1'b1;
        step(18'h0, C_IDLE, 16'h0);

        // Full-word write, then a held read
        step(18'h5, C_WR, 16'hBEEF);
        for (int i = 0; i < LAT + 2; i++) step(18'h5, C_RD, 16'h0);
        chk("beef", 32'(sram_data), 32'hBEEF);

        // Byte lanes
        step(18'h7, C_WR, 16'h1234);
        step(18'h7, C_WR | 5'b01000, 16'hAB00);
        for (int i = 0; i < LAT; i++) step(18'h7, C_RD, 16'h0);
        chk("ab34", 32'(sram_data), 32'hAB34);
        step(18'h7, C_RD | 5'b10000, 16'h0);
        chk("lo_only", 32'(sram_data), 32'hFF34);

        // Changing the address mid-read restarts the latency
        step(18'h1, C_WR, 16'h1111);
        step(18'h2, C_WR, 16'h2222);
        step(18'h1, C_RD, 16'h0);
        for (int i = 0; i < LAT + 1; i++) step(18'h2, C_RD, 16'h0);
        chk("addrchg", 32'(sram_data), 32'h2222);

        // Write with OE_N low
        step(18'h3, C_CONF, 16'h5A5A);
        step(18'h3, C_IDLE, 16'h0);
        for (int i = 0; i < LAT; i++) step(18'h3, C_RD, 16'h0);
        chk("conf_data", 32'(sram_data), 32'h5A5A);

        // Address aliasing above MEM_AW
        step(18'h40, C_WR, 16'hCAFE);
        for (int i = 0; i < LAT; i++) step(18'h0, C_RD, 16'h0);
        chk("alias", 32'(sram_data), 32'hCAFE);

        // Write counter wrap
        for (int i = 0; i < 17; i++) step(18'h9, C_WR | 5'b11000, 16'h0);

        // Random traffic
        ra = 18'h0;
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 99) > 70) begin
                case ($urandom_range(0, 5))
                    0: ra = 18'h0;
                    1: ra = 18'h1;
                    2: ra = 18'h2;
                    3: ra = 18'h40;
                    4: ra = 18'h3FFFF;
                    default: ra = 18'($urandom);
                endcase
            end
            if (r < 55)      rc = C_RD | ($urandom_range(0, 3) == 0 ? 5'({$urandom_range(0, 3), 3'b000}) : 5'b0);
            else if (r < 72) rc = C_WR | 5'({$urandom_range(0, 3), 3'b000});
            else if (r < 75) rc = C_CONF;
            else if (r < 87) rc = 5'($urandom) | 5'b00100;
            else             rc = C_IDLE;
            step(ra, rc, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
